rs232c_rx_fifo: RTL and testbench



---
 rtl/rs232c_rx_fifo.sv | 274 +++++++++++++++++++++++++++
 tb/tb_rs232c_rx_fifo.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232c_rx_fifo.sv
// rs232c_rx_fifo: parametrised RS-232C receiver with parity, stop-bit checking,
// false-start rejection, sticky error flags and a show-ahead receive FIFO.
// The serial input is synchronised, sampled at bit midpoints by a single
// bit-timer FSM, and good frames are pushed into a circular buffer.
module rs232c_rx_fifo #(
    parameter logic [15:0] WTIME      = 16'h0006,
    parameter int          DATA_BITS  = 8,
    parameter int          PARITY     = 0,
    parameter int          STOP_BITS  = 1,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  XRST,
    input  logic                  rx,
    input  logic                  rd_en,
    output logic [DATA_BITS-1:0]  rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun,
    input  logic                  err_clr
);

    localparam int                    DEPTH     = 2 ** DEPTH_LOG2;
    localparam int                    CW        = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0]         CNT_ZERO  = CW'(1'b0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = DEPTH_LOG2'(1'b0);
    localparam logic [15:0]           HALF_W    = WTIME >> 1;
    localparam logic [15:0]           LAST_TICK = WTIME - 16'd1;
    localparam logic [3:0]            DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]            STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_PUSH   = 3'd5,
        ST_BREAK  = 3'd6
    } state_t;

    // Parity mismatch for the received word and parity bit (even or odd sense).
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] data, input logic pbit);
        logic sum;
        sum = (^data) ^ pbit;
        if (PARITY == 2) begin
            parity_bad = ~sum;
        end else begin
            parity_bad = sum;
        end
    endfunction

    logic                  sync1_r, sync2_r, rx_s;
    state_t                state_r, state_s;
    logic [15:0]           timer_r, timer_s;
    logic                  tick_s;
    logic [3:0]            bit_cnt_r, bit_cnt_s;
    logic [DATA_BITS-1:0]  shift_r, shift_s;
    logic                  par_bad_r, par_bad_s;
    logic                  frame_set_s, parity_set_s, overrun_set_s;
    logic [DATA_BITS-1:0]  mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]         count_r, count_s;
    logic                  empty_r, full_r, push_s, pop_s;
    logic                  frame_err_r, parity_err_r, overrun_r;

    assign rx_s   = sync2_r;
    assign tick_s = (timer_r == LAST_TICK);

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge CLK) begin
        if (!XRST) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Receiver state, bit timer, bit counter and shift register.
    always_ff @(posedge CLK) begin
        if (!XRST) begin
            state_r   <= ST_IDLE;
            timer_r   <= 16'd0;
            bit_cnt_r <= 4'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            par_bad_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            par_bad_r <= par_bad_s;
        end
    end

    // Frame decoder: midpoint sampling, false-start rejection, error detection.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r + 16'd1;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        par_bad_s    = par_bad_r;
        frame_set_s  = 1'b0;
        parity_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_s   = 16'd0;
                bit_cnt_s = 4'd0;
                par_bad_s = 1'b0;
                if (!rx_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_r == HALF_W) begin
                    timer_s = 16'd0;
                    // A line already back high at mid-start was only a glitch.
                    if (rx_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    timer_s = 16'd0;
                    shift_s = {rx_s, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == DATA_LAST) begin
                        bit_cnt_s = 4'd0;
                        if (PARITY != 0) begin
                            state_s = ST_PARITY;
                        end else begin
                            state_s = ST_STOP;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    timer_s   = 16'd0;
                    par_bad_s = parity_bad(shift_r, rx_s);
                    state_s   = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    timer_s = 16'd0;
                    if (!rx_s) begin
                        frame_set_s = 1'b1;
                        state_s     = ST_BREAK;
                    end else if (bit_cnt_r == STOP_LAST) begin
                        if (par_bad_r) begin
                            parity_set_s = 1'b1;
                            state_s      = ST_IDLE;
                        end else begin
                            state_s = ST_PUSH;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_PUSH: begin
                timer_s = 16'd0;
                state_s = ST_IDLE;
            end
            ST_BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                timer_s = 16'd0;
                if (rx_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                timer_s = 16'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FIFO push/pop decisions and next occupancy.
    always_comb begin
        push_s        = 1'b0;
        overrun_set_s = 1'b0;
        if (state_r == ST_PUSH) begin
            // A simultaneous read frees the slot, so a full FIFO still accepts the byte.
            if (!full_r || rd_en) begin
                push_s = 1'b1;
            end else begin
                overrun_set_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
        pop_s = rd_en && !empty_r;
        if (push_s && !pop_s) begin
            count_s = count_r + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_s = count_r - CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // FIFO storage, pointers and registered occupancy status.
    always_ff @(posedge CLK) begin
        if (!XRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_BITS{1'b0}};
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_s;
            empty_r <= (count_s == CNT_ZERO);
            full_r  <= (count_s == DEPTH_CNT);
        end
    end

    // Sticky error flags; a new detection wins over a clear in the same cycle.
    always_ff @(posedge CLK) begin
        if (!XRST) begin
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_err_r  <= frame_set_s   | (frame_err_r  & ~err_clr);
            parity_err_r <= parity_set_s  | (parity_err_r & ~err_clr);
            overrun_r    <= overrun_set_s | (overrun_r    & ~err_clr);
        end
    end

    assign rd_data    = mem_r[rd_ptr_r];
    assign empty      = empty_r;
    assign full       = full_r;
    assign count      = count_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_rs232c_rx_fifo.sv
// tb_rs232c_rx_fifo: drives a plain, an even-parity and an odd-parity receiver
// with serial frames and compares every cycle against a queue-based model of
// what each frame must do to the FIFO and the sticky flags.
module tb_rs232c_rx_fifo;

    localparam int W = 6;

    logic       CLK = 1'b0;
    logic       XRST, rx_d, rx_p, rd_en, err_clr;
    logic [7:0] rd_data_a [3];
    logic [4:0] count_a [3];
    logic       empty_a [3];
    logic       full_a [3];
    logic       fe_a [3];
    logic       pe_a [3];
    logic       ov_a [3];

    logic [7:0] mq [3][$];
    bit         m_fe [3];
    bit         m_pe [3];
    bit         m_ov [3];
    bit         chk_en;
    int         checks;
    int         errors;

    rs232c_rx_fifo u_plain (
        .CLK(CLK), .XRST(XRST), .rx(rx_d), .rd_en(rd_en), .rd_data(rd_data_a[0]),
        .empty(empty_a[0]), .full(full_a[0]), .count(count_a[0]), .frame_err(fe_a[0]),
        .parity_err(pe_a[0]), .overrun(ov_a[0]), .err_clr(err_clr)
    );

    rs232c_rx_fifo #(.PARITY(1)) u_even (
        .CLK(CLK), .XRST(XRST), .rx(rx_p), .rd_en(rd_en), .rd_data(rd_data_a[1]),
        .empty(empty_a[1]), .full(full_a[1]), .count(count_a[1]), .frame_err(fe_a[1]),
        .parity_err(pe_a[1]), .overrun(ov_a[1]), .err_clr(err_clr)
    );

    rs232c_rx_fifo #(.PARITY(2)) u_odd (
        .CLK(CLK), .XRST(XRST), .rx(rx_p), .rd_en(rd_en), .rd_data(rd_data_a[2]),
        .empty(empty_a[2]), .full(full_a[2]), .count(count_a[2]), .frame_err(fe_a[2]),
        .parity_err(pe_a[2]), .overrun(ov_a[2]), .err_clr(err_clr)
    );

    // 14 ns clock
    always #7 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(posedge CLK);
            #2;
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("u%0d.count", i), 32'(count_a[i]), 32'(mq[i].size()));
                    chk($sformatf("u%0d.empty", i), 32'(empty_a[i]), 32'(mq[i].size() == 0));
                    chk($sformatf("u%0d.full", i), 32'(full_a[i]), 32'(mq[i].size() == 16));
                    chk($sformatf("u%0d.frame_err", i), 32'(fe_a[i]), 32'(m_fe[i]));
                    chk($sformatf("u%0d.parity_err", i), 32'(pe_a[i]), 32'(m_pe[i]));
                    chk($sformatf("u%0d.overrun", i), 32'(ov_a[i]), 32'(m_ov[i]));
                    if (mq[i].size() != 0) begin
                        chk($sformatf("u%0d.rd_data", i), 32'(rd_data_a[i]), 32'(mq[i][0]));
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            m_fe[i] = 1'b0;
            m_pe[i] = 1'b0;
            m_ov[i] = 1'b0;
        end
    endtask

    // Outcome of one complete frame for receiver i (0 none, 1 even, 2 odd parity).
    task automatic model_frame(input int i, input logic [7:0] d, input logic pbit, input logic stop_ok);
        int ones;
        ones = $countones(d) + int'(pbit);
        if (!stop_ok) m_fe[i] = 1'b1;
        else if (i == 1 && (ones % 2) != 0) m_pe[i] = 1'b1;
        else if (i == 2 && (ones % 2) != 1) m_pe[i] = 1'b1;
        else if (mq[i].size() == 16) m_ov[i] = 1'b1;
        else mq[i].push_back(d);
    endtask

    task automatic set_line(input int ln, input logic v);
        if (ln == 0) rx_d = v;
        else rx_p = v;
    endtask

    task automatic bit_time(input int ln, input logic v);
        set_line(ln, v);
        repeat (W) @(negedge CLK);
    endtask

    task automatic send_frame(input int ln, input logic [7:0] d, input logic pbit, input logic stop_v);
        bit_time(ln, 1'b0);
        for (int b = 0; b < 8; b++) bit_time(ln, d[b]);
        if (ln == 1) bit_time(ln, pbit);
        bit_time(ln, stop_v);
    endtask

    task automatic frame(input int ln, input logic [7:0] d, input logic pbit, input logic stop_ok, input int hold);
        chk_en = 1'b0;
        send_frame(ln, d, pbit, stop_ok);
        if (!stop_ok) begin
            repeat (hold) @(negedge CLK);
            set_line(ln, 1'b1);
        end
        repeat (W + 4) @(negedge CLK);
        if (ln == 0) begin
            model_frame(0, d, pbit, stop_ok);
        end else begin
            model_frame(1, d, pbit, stop_ok);
            model_frame(2, d, pbit, stop_ok);
        end
        chk_en = 1'b1;
    endtask

    task automatic model_pop_all();
        for (int i = 0; i < 3; i++) begin
            if (mq[i].size() != 0) void'(mq[i].pop_front());
        end
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        @(posedge CLK);
        model_pop_all();
        @(negedge CLK);
        rd_en = 1'b0;
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            m_fe[i] = 1'b0;
            m_pe[i] = 1'b0;
            m_ov[i] = 1'b0;
        end
        @(negedge CLK);
        err_clr = 1'b0;
    endtask

    task automatic glitch(input int ln, input int len);
        set_line(ln, 1'b0);
        repeat (len) @(negedge CLK);
        set_line(ln, 1'b1);
        repeat (2 * W) @(negedge CLK);
    endtask

    initial begin
        logic [7:0] d;
        checks  = 0;
        errors  = 0;
        chk_en  = 1'b0;
        XRST    = 1'b0;
        rx_d    = 1'b1;
        rx_p    = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        model_reset();
        fork
            compare_loop();
        join_none

        // Reset with the lines toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            rx_d = ~rx_d;
            rx_p = ~rx_p;
        end
        @(negedge CLK);
        rx_d = 1'b1;
        rx_p = 1'b1;
        chk("reset.empty", 32'(empty_a[0]), 32'd1);
        chk("reset.count", 32'(count_a[0]), 32'd0);
        chk("reset.flags", {29'd0, fe_a[0], pe_a[0], ov_a[0]}, 32'd0);
        chk("reset.rd_data", 32'(rd_data_a[0]), 32'd0);
        XRST = 1'b1;
        chk_en = 1'b1;
        repeat (20) @(negedge CLK);
        chk("idle.count", 32'(count_a[0]), 32'd0);

        // Back-to-back burst, no reads
        chk_en = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(0, 8'(k), 1'b0, 1'b1);
        repeat (W + 4) @(negedge CLK);
        for (int k = 1; k <= 4; k++) model_frame(0, 8'(k), 1'b0, 1'b1);
        chk_en = 1'b1;
        chk("burst.count", 32'(count_a[0]), 32'd4);
        chk("burst.head", 32'(rd_data_a[0]), 32'h01);
        for (int k = 0; k < 4; k++) begin
            do_read();
            if (k < 3) chk("burst.pop_data", 32'(rd_data_a[0]), 32'(k + 2));
            else chk("burst.empty", 32'(empty_a[0]), 32'd1);
        end
        do_read();
        chk("burst.extra_pop", 32'(count_a[0]), 32'd0);

        // Short glitches on both lines
        glitch(0, 2);
        glitch(1, 2);
        chk("glitch.count", 32'(count_a[0]), 32'd0);

        // Frame error, held-low line, then recovery
        frame(0, 8'h55, 1'b0, 1'b0, 20);
        chk("ferr.flag", 32'(fe_a[0]), 32'd1);
        chk("ferr.count", 32'(count_a[0]), 32'd0);
        do_clr();
        frame(0, 8'hA5, 1'b0, 1'b1, 0);
        chk("recover.flag", 32'(fe_a[0]), 32'd0);
        chk("recover.count", 32'(count_a[0]), 32'd1);
        chk("recover.data", 32'(rd_data_a[0]), 32'hA5);
        do_read();

        // Parity: even and odd receivers see the same line
        frame(1, 8'h07, 1'b0, 1'b1, 0);
        chk("even.p0.perr", 32'(pe_a[1]), 32'd1);
        chk("even.p0.count", 32'(count_a[1]), 32'd0);
        chk("odd.p0.count", 32'(count_a[2]), 32'd1);
        chk("odd.p0.data", 32'(rd_data_a[2]), 32'h07);
        frame(1, 8'h07, 1'b1, 1'b1, 0);
        chk("even.p1.count", 32'(count_a[1]), 32'd1);
        chk("even.p1.data", 32'(rd_data_a[1]), 32'h07);
        chk("odd.p1.perr", 32'(pe_a[2]), 32'd1);
        do_clr();
        do_read();

        // Overrun
        for (int k = 0; k <= 16; k++) frame(0, 8'(k), 1'b0, 1'b1, 0);
        chk("ovr.full", 32'(full_a[0]), 32'd1);
        chk("ovr.count", 32'(count_a[0]), 32'd16);
        chk("ovr.flag", 32'(ov_a[0]), 32'd1);
        chk("ovr.head", 32'(rd_data_a[0]), 32'h00);
        chk_en = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1);
        @(negedge CLK);
        rd_en = 1'b1;
        @(posedge CLK);
        model_pop_all();
        @(negedge CLK);
        rd_en = 1'b0;
        repeat (W + 4) @(negedge CLK);
        model_frame(0, 8'h11, 1'b0, 1'b1);
        chk_en = 1'b1;
        chk("ovr.push_pop_count", 32'(count_a[0]), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("ovr.last", 32'(rd_data_a[0]), 32'h11);
            do_read();
        end
        chk("ovr.drained", 32'(empty_a[0]), 32'd1);
        do_clr();

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            d = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 6))
                0, 1: frame(0, d, 1'b0, 1'b1, 0);
                2: frame(1, d, 1'($urandom_range(0, 1)), 1'b1, 0);
                3: repeat ($urandom_range(1, 5)) do_read();
                4: glitch($urandom_range(0, 1), $urandom_range(1, 2));
                5: do_clr();
                6: frame($urandom_range(0, 1), d, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(5, 30));
                default: repeat (4) @(negedge CLK);
            endcase
        end

        // Reset in the middle of a frame
        frame(0, 8'h3C, 1'b0, 1'b1, 0);
        chk_en = 1'b0;
        rx_d = 1'b0;
        repeat (3 * W) @(negedge CLK);
        XRST = 1'b0;
        rx_d = 1'b1;
        repeat (2) @(negedge CLK);
        XRST = 1'b1;
        model_reset();
        @(negedge CLK);
        chk_en = 1'b1;
        chk("midreset.count", 32'(count_a[0]), 32'd0);
        chk("midreset.flags", {29'd0, fe_a[0], pe_a[0], ov_a[0]}, 32'd0);
        repeat (3 * W) @(negedge CLK);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
